mem_ctrl: RTL and testbench

Memory controller that sequences the single byte-wide RAM/IO port between two requesters: instruction fetch (4-byte reads on i-cache miss) and the load/store buffer (1/2/4-byte loads and stores). It serialises each access into byte transactions, reassembles read data little-endian, and arbitrates with alternating priority. It sits between the i-cache/LSB and the top-level `mem_*` pins.

---
 rtl/mem_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates the byte-wide RAM/IO port between instruction fetch
// and the load/store buffer. Each access is split into byte transactions;
// read bytes are reassembled little-endian. Ties alternate priority.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no access in flight, arbitrate at each edge
// S_FETCH | 4-byte instruction read in flight (flush aborts it)
// S_LOAD  | 1/2/4-byte load in flight
// S_STORE | 1/2/4-byte store in flight, may stall on a full IO buffer
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rdy,
    input  logic        i_ic_req,
    input  logic [31:0] i_ic_addr,
    output logic        o_ic_valid,
    output logic [31:0] o_ic_data,
    input  logic        i_flush,
    input  logic        i_ls_req,
    input  logic        i_ls_wr,
    input  logic [31:0] i_ls_addr,
    input  logic [2:0]  i_ls_len,
    input  logic [31:0] i_ls_wdata,
    output logic        o_ls_valid,
    output logic [31:0] o_ls_rdata,
    input  logic [7:0]  i_mem_din,
    output logic [7:0]  o_mem_dout,
    output logic [31:0] o_mem_a,
    output logic        o_mem_wr,
    input  logic        i_io_buffer_full
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_STORE} state_t;

    state_t      r_state;
    logic        r_last_ls;
    logic [31:0] r_base;
    logic [31:0] r_wdata;
    logic [31:0] r_buf;
    logic [2:0]  r_len;
    logic [2:0]  r_cnt;
    logic        r_io;
    logic        r_mem_wr;
    logic [7:0]  r_mem_dout;
    logic [31:0] r_mem_a;
    logic        r_ic_valid;
    logic [31:0] r_ic_data;
    logic        r_ls_valid;
    logic [31:0] r_ls_rdata;

    logic        w_grant_ic;
    logic        w_ls_io;
    logic [2:0]  w_cnt_nxt;
    logic [1:0]  w_cap_idx;
    logic [31:0] w_cap;
    logic [7:0]  w_wr_byte;
    logic        w_io_blocked;

    // Fetch wins only when LSB is idle or LSB had the previous grant; never on a flush edge
    assign w_grant_ic   = i_ic_req && !i_flush && (!i_ls_req || r_last_ls);
    assign w_ls_io      = (i_ls_addr[17:16] == 2'b11);
    assign w_cnt_nxt    = r_cnt + 3'd1;
    // Byte arriving now belongs to the address issued one cycle earlier
    assign w_cap_idx    = r_cnt[1:0] - 2'd1;
    assign w_cap        = r_buf | ({24'd0, i_mem_din} << {w_cap_idx, 3'b000});
    assign w_wr_byte    = r_wdata[{w_cnt_nxt[1:0], 3'b000} +: 8];
    assign w_io_blocked = r_io && i_io_buffer_full;

    assign o_mem_wr   = r_mem_wr & i_rdy;
    assign o_mem_a    = r_mem_a;
    assign o_mem_dout = r_mem_dout;
    assign o_ic_valid = r_ic_valid;
    assign o_ic_data  = r_ic_data;
    assign o_ls_valid = r_ls_valid;
    assign o_ls_rdata = r_ls_rdata;

    // Arbitration, byte sequencing and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_last_ls  <= 1'b0;
            r_base     <= 32'd0;
            r_wdata    <= 32'd0;
            r_buf      <= 32'd0;
            r_len      <= 3'd0;
            r_cnt      <= 3'd0;
            r_io       <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_mem_dout <= 8'd0;
            r_mem_a    <= 32'd0;
            r_ic_valid <= 1'b0;
            r_ic_data  <= 32'd0;
            r_ls_valid <= 1'b0;
            r_ls_rdata <= 32'd0;
        end else if (i_rdy) begin
            r_ic_valid <= 1'b0;
            r_ls_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 3'd0;
                    r_buf <= 32'd0;
                    if (w_grant_ic) begin
                        r_state   <= S_FETCH;
                        r_last_ls <= 1'b0;
                        r_base    <= i_ic_addr;
                        r_len     <= 3'd4;
                        r_mem_a   <= i_ic_addr;
                    end else if (i_ls_req) begin
                        r_last_ls <= 1'b1;
                        r_base    <= i_ls_addr;
                        r_len     <= i_ls_len;
                        r_wdata   <= i_ls_wdata;
                        r_io      <= w_ls_io;
                        r_mem_a   <= i_ls_addr;
                        if (i_ls_wr) begin
                            r_state    <= S_STORE;
                            r_mem_dout <= i_ls_wdata[7:0];
                            r_mem_wr   <= !(w_ls_io && i_io_buffer_full);
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_FETCH, S_LOAD: begin
                    if (r_state == S_FETCH && i_flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt < r_len) begin
                            r_mem_a <= r_base + {29'd0, w_cnt_nxt};
                        end
                        if (r_cnt != 3'd0) begin
                            r_buf <= w_cap;
                            if (r_cnt == r_len) begin
                                r_state <= S_IDLE;
                                if (r_state == S_FETCH) begin
                                    r_ic_valid <= 1'b1;
                                    r_ic_data  <= w_cap;
                                end else begin
                                    r_ls_valid <= 1'b1;
                                    r_ls_rdata <= w_cap;
                                end
                            end
                        end
                    end
                end
                S_STORE: begin
                    if (r_mem_wr) begin
                        if (w_cnt_nxt == r_len) begin
                            r_mem_wr   <= 1'b0;
                            r_ls_valid <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_cnt      <= w_cnt_nxt;
                            r_mem_a    <= r_base + {29'd0, w_cnt_nxt};
                            r_mem_dout <= w_wr_byte;
                            r_mem_wr   <= !w_io_blocked;
                        end
                    end else begin
                        // Stalled byte: address and data already on the bus
                        r_mem_wr <= !w_io_blocked;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl. Each scenario is described by a handful of
// edge numbers (edge 1 = first edge after the scenario starts) at which
// requests, flush, rdy, io_buffer_full and rst change; the run task logs
// what the port does and the scenario tasks compare against hand values.
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        flush;
    logic        ls_req;
    logic        ls_wr;
    logic [31:0] ls_addr;
    logic [2:0]  ls_len;
    logic [31:0] ls_wdata;
    logic [7:0]  mem_din;
    logic        io_full;
    logic        o_ic_valid;
    logic [31:0] o_ic_data;
    logic        o_ls_valid;
    logic [31:0] o_ls_rdata;
    logic [7:0]  o_mem_dout;
    logic [31:0] o_mem_a;
    logic        o_mem_wr;

    int vecs = 0;
    int errs = 0;

    // scenario configuration (0 = never)
    int ic_at, ls_at, ls_reps, rdy_lo, rdy_n, full_lo, full_n, flush_at, rst_at;
    // observations
    int          e_ic, e_ls, e_ls2, n_ic, n_ls, n_wr, first_wr;
    logic [31:0] d_ic, d_ls;
    logic [31:0] a_log [0:63];
    logic [31:0] w_addr [0:15];
    logic [7:0]  w_dat [0:15];
    logic        sn_wr, sn_icv, sn_lsv;
    logic [7:0]  sn_dout;
    logic [31:0] sn_a, sn_icd, sn_lsd;

    logic [7:0] ram [0:262143];

    mem_ctrl dut (
        .clk(clk), .rst(rst), .i_rdy(rdy),
        .i_ic_req(ic_req), .i_ic_addr(ic_addr),
        .o_ic_valid(o_ic_valid), .o_ic_data(o_ic_data),
        .i_flush(flush),
        .i_ls_req(ls_req), .i_ls_wr(ls_wr), .i_ls_addr(ls_addr),
        .i_ls_len(ls_len), .i_ls_wdata(ls_wdata),
        .o_ls_valid(o_ls_valid), .o_ls_rdata(o_ls_rdata),
        .i_mem_din(mem_din), .o_mem_dout(o_mem_dout), .o_mem_a(o_mem_a),
        .o_mem_wr(o_mem_wr), .i_io_buffer_full(io_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM with one-cycle read latency, frozen along with the system when rdy is low
    always @(posedge clk) begin
        if (rst) begin
            ram[18'h00100] <= 8'h13; ram[18'h00101] <= 8'h05;
            ram[18'h00102] <= 8'h00; ram[18'h00103] <= 8'h00;
            ram[18'h00200] <= 8'h34; ram[18'h00201] <= 8'h12;
            ram[18'h00300] <= 8'h11; ram[18'h00301] <= 8'h22;
            ram[18'h00302] <= 8'h33; ram[18'h00303] <= 8'h44;
        end else if (rdy) begin
            if (o_mem_wr) ram[o_mem_a[17:0]] <= o_mem_dout;
            mem_din <= ram[o_mem_a[17:0]];
        end
    end

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; ic_req = 1'b0; ls_req = 1'b0; flush = 1'b0;
        io_full = 1'b0; ic_addr = 32'h100; ls_wr = 1'b0; ls_addr = 32'h0;
        ls_len = 3'd1; ls_wdata = 32'h0;
        ic_at = 0; ls_at = 0; ls_reps = 0; rdy_lo = 0; rdy_n = 0;
        full_lo = 0; full_n = 0; flush_at = 0; rst_at = 0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input int budget);
        e_ic = -1; e_ls = -1; e_ls2 = -1; n_ic = 0; n_ls = 0; n_wr = 0; first_wr = -1;
        d_ic = 32'hx; d_ls = 32'hx;
        for (int n = 1; n <= budget; n++) begin
            if (n == ic_at) ic_req = 1'b1;
            if (n == ls_at) ls_req = 1'b1;
            rdy     = !(n >= rdy_lo && n < rdy_lo + rdy_n);
            io_full = (n >= full_lo && n < full_lo + full_n);
            flush   = (n == flush_at);
            if (flush) ic_req = 1'b0;
            rst = (n == rst_at);
            if (rst) begin ic_req = 1'b0; ls_req = 1'b0; end
            @(posedge clk); @(negedge clk);
            if (n < 64) a_log[n] = o_mem_a;
            if (o_mem_wr) begin
                if (n_wr < 16) begin w_addr[n_wr] = o_mem_a; w_dat[n_wr] = o_mem_dout; end
                if (n_wr == 0) first_wr = n;
                n_wr++;
            end
            if (o_ic_valid) begin
                n_ic++;
                if (e_ic < 0) begin e_ic = n; d_ic = o_ic_data; end
                ic_req = 1'b0;
            end
            if (o_ls_valid) begin
                n_ls++;
                if (e_ls < 0) begin e_ls = n; d_ls = o_ls_rdata; end
                else if (e_ls2 < 0) e_ls2 = n;
                if (ls_reps > 0) ls_reps--;
                else ls_req = 1'b0;
            end
            if (n == rst_at) begin
                sn_wr = o_mem_wr; sn_icv = o_ic_valid; sn_lsv = o_ls_valid;
                sn_dout = o_mem_dout; sn_a = o_mem_a; sn_icd = o_ic_data; sn_lsd = o_ls_rdata;
            end
        end
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; io_full = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vecs++; if (o_mem_wr !== 1'b0) begin errs++; $display("FAIL reset_mem_wr: got %b want 0", o_mem_wr); end
        vecs++; if (o_mem_a !== 32'h0) begin errs++; $display("FAIL reset_mem_a: got %h want 0", o_mem_a); end
        vecs++; if (o_mem_dout !== 8'h0) begin errs++; $display("FAIL reset_mem_dout: got %h want 0", o_mem_dout); end
        vecs++; if (o_ic_valid !== 1'b0 || o_ls_valid !== 1'b0) begin errs++; $display("FAIL reset_valids: got %b%b want 00", o_ic_valid, o_ls_valid); end
        vecs++; if (o_ic_data !== 32'h0 || o_ls_rdata !== 32'h0) begin errs++; $display("FAIL reset_data: got %h/%h want 0/0", o_ic_data, o_ls_rdata); end
    endtask

    task automatic test_fetch();
        do_reset();
        ic_addr = 32'h100; ic_at = 1;
        run(10);
        vecs++; if (e_ic !== 6) begin errs++; $display("FAIL fetch_latency: got edge %0d want 6", e_ic); end
        vecs++; if (d_ic !== 32'h00000513) begin errs++; $display("FAIL fetch_data: got %h want 00000513", d_ic); end
        vecs++; if (n_ic !== 1) begin errs++; $display("FAIL fetch_pulses: got %0d want 1", n_ic); end
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (a_log[i+1] !== 32'h100 + i)
                begin errs++; $display("FAIL fetch_addr%0d: got %h want %h", i, a_log[i+1], 32'h100 + i); end
        end
        vecs++; if (n_wr !== 0 || n_ls !== 0) begin errs++; $display("FAIL fetch_side: got wr=%0d lsv=%0d want 0/0", n_wr, n_ls); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ic_addr = 32'h100; ls_addr = 32'h200; ls_len = 3'd2; ls_wr = 1'b0;
        ic_at = 1; ls_at = 1; ls_reps = 1;
        run(20);
        vecs++; if (a_log[1] !== 32'h200) begin errs++; $display("FAIL tie1_grant: got %h want 00000200", a_log[1]); end
        vecs++; if (e_ls !== 4) begin errs++; $display("FAIL tie1_latency: got edge %0d want 4", e_ls); end
        vecs++; if (d_ls !== 32'h00001234) begin errs++; $display("FAIL tie1_data: got %h want 00001234", d_ls); end
        vecs++; if (a_log[5] !== 32'h100) begin errs++; $display("FAIL tie2_grant: got %h want 00000100", a_log[5]); end
        vecs++; if (e_ic !== 10) begin errs++; $display("FAIL tie2_fetch_edge: got %0d want 10", e_ic); end
        vecs++; if (d_ic !== 32'h00000513) begin errs++; $display("FAIL tie2_fetch_data: got %h want 00000513", d_ic); end
        vecs++; if (a_log[11] !== 32'h200) begin errs++; $display("FAIL tie2_ls_regrant: got %h want 00000200", a_log[11]); end
        vecs++; if (e_ls2 !== 14) begin errs++; $display("FAIL tie2_ls_edge: got %0d want 14", e_ls2); end
        vecs++; if (n_ls !== 2 || n_ic !== 1) begin errs++; $display("FAIL tie_pulses: got ls=%0d ic=%0d want 2/1", n_ls, n_ic); end
    endtask

    task automatic test_flush();
        do_reset();
        ic_addr = 32'h100; ls_addr = 32'h200; ls_len = 3'd1; ls_wr = 1'b0;
        ic_at = 1; ls_at = 4; flush_at = 4;
        run(12);
        vecs++; if (n_ic !== 0) begin errs++; $display("FAIL flush_no_ic_valid: got %0d pulses want 0", n_ic); end
        vecs++; if (a_log[5] !== 32'h200) begin errs++; $display("FAIL flush_ls_grant: got %h want 00000200", a_log[5]); end
        vecs++; if (e_ls !== 7) begin errs++; $display("FAIL flush_ls_edge: got %0d want 7", e_ls); end
        vecs++; if (d_ls !== 32'h00000034) begin errs++; $display("FAIL flush_ls_data: got %h want 00000034", d_ls); end
    endtask

    task automatic test_rdy_stall();
        do_reset();
        ls_addr = 32'h300; ls_len = 3'd4; ls_wr = 1'b0;
        ls_at = 1; rdy_lo = 3; rdy_n = 2;
        run(14);
        vecs++; if (e_ls !== 8) begin errs++; $display("FAIL rdy_latency: got edge %0d want 8", e_ls); end
        vecs++; if (d_ls !== 32'h44332211) begin errs++; $display("FAIL rdy_data: got %h want 44332211", d_ls); end
        vecs++; if (n_wr !== 0 || n_ls !== 1) begin errs++; $display("FAIL rdy_side: got wr=%0d lsv=%0d want 0/1", n_wr, n_ls); end
    endtask

    task automatic test_store_io();
        logic [7:0] exp_b [0:3];
        exp_b[0] = 8'h78; exp_b[1] = 8'h56; exp_b[2] = 8'h34; exp_b[3] = 8'h12;
        do_reset();
        ls_wr = 1'b1; ls_addr = 32'h30000; ls_len = 3'd4; ls_wdata = 32'h12345678;
        ls_at = 1; full_lo = 1; full_n = 3;
        run(14);
        vecs++; if (first_wr !== 4) begin errs++; $display("FAIL io_first_write: got edge %0d want 4", first_wr); end
        vecs++; if (n_wr !== 4) begin errs++; $display("FAIL io_write_count: got %0d want 4", n_wr); end
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (w_addr[i] !== 32'h30000 + i || w_dat[i] !== exp_b[i])
                begin errs++; $display("FAIL io_byte%0d: got %h@%h want %h@%h", i, w_dat[i], w_addr[i], exp_b[i], 32'h30000 + i); end
        end
        vecs++; if (e_ls !== 8 || n_ls !== 1) begin errs++; $display("FAIL io_valid: got edge %0d x%0d want edge 8 x1", e_ls, n_ls); end
    endtask

    task automatic test_store_plain();
        do_reset();
        ls_wr = 1'b1; ls_addr = 32'h400; ls_len = 3'd2; ls_wdata = 32'h0000AABB;
        ls_at = 1;
        run(8);
        vecs++; if (first_wr !== 1 || n_wr !== 2) begin errs++; $display("FAIL st_writes: got first %0d count %0d want 1/2", first_wr, n_wr); end
        vecs++; if (w_dat[0] !== 8'hBB || w_addr[0] !== 32'h400) begin errs++; $display("FAIL st_byte0: got %h@%h want bb@00000400", w_dat[0], w_addr[0]); end
        vecs++; if (w_dat[1] !== 8'hAA || w_addr[1] !== 32'h401) begin errs++; $display("FAIL st_byte1: got %h@%h want aa@00000401", w_dat[1], w_addr[1]); end
        vecs++; if (e_ls !== 3) begin errs++; $display("FAIL st_valid_edge: got %0d want 3", e_ls); end
    endtask

    task automatic test_reset_mid_store();
        do_reset();
        ls_wr = 1'b1; ls_addr = 32'h500; ls_len = 3'd4; ls_wdata = 32'hCAFEF00D;
        ls_at = 1; rst_at = 3;
        run(10);
        vecs++; if (n_wr !== 2) begin errs++; $display("FAIL rst_write_count: got %0d want 2", n_wr); end
        vecs++; if (w_dat[0] !== 8'h0D || w_dat[1] !== 8'hF0) begin errs++; $display("FAIL rst_bytes: got %h %h want 0d f0", w_dat[0], w_dat[1]); end
        vecs++; if (n_ls !== 0) begin errs++; $display("FAIL rst_no_valid: got %0d pulses want 0", n_ls); end
        vecs++; if (sn_wr !== 1'b0 || sn_icv !== 1'b0 || sn_lsv !== 1'b0) begin errs++; $display("FAIL rst_ctrl_zero: got wr=%b icv=%b lsv=%b want 0", sn_wr, sn_icv, sn_lsv); end
        vecs++; if (sn_a !== 32'h0 || sn_dout !== 8'h0) begin errs++; $display("FAIL rst_bus_zero: got a=%h dout=%h want 0", sn_a, sn_dout); end
        vecs++; if (sn_icd !== 32'h0 || sn_lsd !== 32'h0) begin errs++; $display("FAIL rst_data_zero: got %h/%h want 0/0", sn_icd, sn_lsd); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_back_to_back();
        test_flush();
        test_rdy_stall();
        test_store_io();
        test_store_plain();
        test_reset_mid_store();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
